imem_boot_sequencer: RTL and testbench

// - Boot controller for the single-cycle MIPS system: holds the core in reset, streams a program

---
 rtl/imem_boot_sequencer_pkg.sv | 7 +
 rtl/imem_boot_sequencer_if.sv | 19 +
 rtl/imem_boot_sequencer_byte_packer.sv | 30 +++
 rtl/imem_boot_sequencer.sv | 124 ++++++++++++
 tb/tb_imem_boot_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_sequencer_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
package imem_boot_pkg;
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, RUN} state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;
endpackage

// File: rtl/imem_boot_sequencer_if.sv
// Byte-stream input and instruction-memory write port of the boot sequencer.
interface imem_boot_sequencer_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wd
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wd
    );
endinterface

// File: rtl/imem_boot_sequencer_byte_packer.sv
// Assembles four bytes into one little-endian 32-bit word.
module byte_packer
    import imem_boot_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);
    logic [LANE_W-1:0] lane;

    // High on the push that completes the word; word_out holds it from the next cycle.
    assign full = push && (lane == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lane     <= '0;
            word_out <= '0;
        end else if (clear) begin
            lane     <= '0;
            word_out <= '0;
        end else if (push) begin
            word_out[8*lane +: 8] <= byte_in;
            lane                  <= lane + 1'b1;
        end
    end
endmodule

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer: holds the core in reset, streams a program into imem, then releases the core.
//   state | meaning
//   IDLE  | core held, waiting for start
//   RECV  | collecting bytes of the current word
//   WRITE | one-cycle imem write of the assembled word
//   DONE  | one-cycle completion pulse, core still held
//   RUN   | core released and executing
module imem_boot_sequencer
    import imem_boot_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    imem_boot_sequencer_if.master bus,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int                  TIMER_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_WIDTH:0] MAX_LEN    = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [TIMER_W-1:0]    timer;
    logic                  hs, word_full, last_word, start_ok, err_set;
    logic [31:0]           word;

    assign hs        = bus.byte_valid && bus.byte_ready;
    assign last_word = ({1'b0, word_idx} + 1'b1) == len_q;

    byte_packer u_packer (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (start_ok),
        .push     (hs),
        .byte_in  (bus.byte_data),
        .word_out (word),
        .full     (word_full)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else if (len > MAX_LEN) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        start_ok  = 1'b1;
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                if (hs) begin
                    if (word_full) state_nxt = WRITE;
                end else if (timer == '0) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE:   state_nxt = last_word ? DONE : RECV;
            DONE:    state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // The idle timer is a down-counter reloaded on every accepted byte and on entry to RECV.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            len_q    <= '0;
            word_idx <= '0;
            timer    <= '0;
            err      <= 1'b0;
        end else begin
            if (start_ok) begin
                len_q    <= len;
                word_idx <= '0;
                timer    <= TIMER_LOAD;
                err      <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
            case (state)
                RECV: begin
                    if (hs)               timer <= TIMER_LOAD;
                    else if (timer != '0) timer <= timer - 1'b1;
                end
                WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + 1'b1;
                        timer    <= TIMER_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = (state == RECV);
    assign bus.imem_we    = (state == WRITE);
    assign bus.imem_addr  = 32'({word_idx, 2'b00});
    assign bus.imem_wd    = word;
    assign core_hold      = (state != RUN);
    assign busy           = (state == RECV) || (state == WRITE);
    assign done           = (state == DONE);
endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Self-checking bench for imem_boot_sequencer against a transaction-level scoreboard.
module tb_imem_boot_sequencer;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       start = 1'b0;
    logic [8:0] len = '0;
    logic       core_hold, busy, done, err;

    imem_boot_sequencer_if bus();

    imem_boot_sequencer #(.ADDR_WIDTH(8), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .len(len), .bus(bus),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;
    int cyc = 0, exp_done_cyc = -1, words_left = 0, hs_cnt = 0, last_hs_cyc = -10;
    bit exp_hold = 1'b1, mon_en = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;
    logic [7:0]  prog [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack_word(input int i);
        logic [31:0] w = 0;
        for (int b = 0; b < 4; b++) w = w + (32'(prog[4*i+b]) << (8*b));
        return w;
    endfunction

    // Scoreboard: expected writes in order, done exactly one cycle after the last write,
    // core held from the cycle after any start until the cycle after done.
    always @(negedge CLK) begin
        if (RESET && mon_en) begin
            logic [63:0] e;
            cyc++;
            chk("done", 32'(done), 32'(cyc == exp_done_cyc));
            chk("core_hold", 32'(core_hold), 32'(exp_hold));
            if (bus.imem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h required none", bus.imem_addr, bus.imem_wd);
                end else begin
                    e = exp_q.pop_front();
                    chk("imem_addr", bus.imem_addr, e[63:32]);
                    chk("imem_wd", bus.imem_wd, e[31:0]);
                    chk("hs_per_word", 32'(hs_cnt), 32'd4);
                    chk("write_latency", 32'(cyc - last_hs_cyc), 32'd1);
                    last_wr_addr = bus.imem_addr;
                    last_wr_data = bus.imem_wd;
                    hs_cnt = 0;
                    words_left--;
                    if (words_left == 0) exp_done_cyc = cyc + 1;
                end
            end
            if (bus.byte_valid && bus.byte_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (start) exp_hold = 1'b1;
            if (cyc == exp_done_cyc) exp_hold = 1'b0;
        end
    end

    task automatic prep(input int l);
        for (int i = 0; i < l; i++) exp_q.push_back({32'(i*4), pack_word(i)});
        words_left = l;
    endtask

    task automatic pulse_start(input int l);
        start = 1'b1;
        len   = 9'(l);
        if (l == 0) exp_done_cyc = cyc + 2;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        do begin @(negedge CLK); n++; end while (!bus.byte_ready && n < 50);
        if (!bus.byte_ready) begin
            checks++; errors++;
            $display("FAIL byte_ready_wait actual=0 required=1 within 50 cycles");
        end
        @(posedge CLK); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge CLK); n++; end while (!done && n < 400);
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_wait actual=0 required=1 within 400 cycles");
        end
        @(posedge CLK); #1;
    endtask

    task automatic run_load(input int l, input int maxgap);
        prep(l);
        pulse_start(l);
        for (int i = 0; i < 4*l; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin @(posedge CLK); #1; end
            send_byte(prog[i]);
        end
        wait_done();
    endtask

    task automatic randomize_prog();
        for (int i = 0; i < 64; i++) prog[i] = 8'($urandom);
    endtask

    task automatic load_t1_prog();
        logic [7:0] t1 [0:7];
        t1 = '{8'h13, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'h09, 8'h21};
        for (int i = 0; i < 8; i++) prog[i] = t1[i];
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_imem_addr"}, bus.imem_addr, 32'd0);
        chk({tag, "_imem_wd"}, bus.imem_wd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        #1;
        check_reset_values("reset");
        @(negedge CLK); #2 RESET = 1'b1;
        @(posedge CLK); #1 mon_en = 1'b1;

        // Directed two-word program
        load_t1_prog();
        chk("model_word0", pack_word(0), 32'h20080013);
        chk("model_word1", pack_word(1), 32'h2109FFFF);
        run_load(2, 0);
        chk("t1_last_addr", last_wr_addr, 32'h4);
        chk("t1_last_data", last_wr_data, 32'h2109FFFF);
        @(negedge CLK);
        chk("t1_released", 32'(core_hold), 32'd0);
        @(posedge CLK); #1;

        // Backpressure with gapped byte_valid, same program then random ones
        run_load(2, 10);
        chk("bp_last_data", last_wr_data, 32'h2109FFFF);
        for (int k = 0; k < 3; k++) begin
            randomize_prog();
            run_load(int'($urandom_range(6, 1)), 10);
        end

        // Re-load from RUN
        randomize_prog();
        prep(1);
        pulse_start(1);
        chk("reload_hold", 32'(core_hold), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        wait_done();
        chk("reload_addr", last_wr_addr, 32'h0);

        // Over-length request
        pulse_start(257);
        repeat (5) @(negedge CLK);
        chk("badlen_err", 32'(err), 32'd1);
        chk("badlen_hold", 32'(core_hold), 32'd1);
        chk("badlen_busy", 32'(busy), 32'd0);
        @(posedge CLK); #1;

        // Zero-length request from IDLE
        pulse_start(0);
        repeat (3) @(negedge CLK);
        chk("len0_released", 32'(core_hold), 32'd0);
        @(posedge CLK); #1;

        // Timeout after three bytes
        randomize_prog();
        prep(2);
        pulse_start(2);
        for (int i = 0; i < 3; i++) send_byte(prog[i]);
        for (int k = 1; k <= 17; k++) begin
            @(negedge CLK);
            chk($sformatf("timeout_err_c%0d", k), 32'(err), 32'(k == 17));
        end
        chk("timeout_hold", 32'(core_hold), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        @(posedge CLK); #1;
        exp_q.delete();
        words_left = 0;
        hs_cnt = 0;
        run_load(1, 2);
        chk("err_cleared", 32'(err), 32'd0);

        // Reset in the middle of a word
        randomize_prog();
        prep(2);
        pulse_start(2);
        send_byte(prog[0]);
        send_byte(prog[1]);
        #2;
        mon_en = 1'b0;
        RESET  = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        words_left   = 0;
        hs_cnt       = 0;
        exp_hold     = 1'b1;
        exp_done_cyc = -1;
        @(negedge CLK); #2 RESET = 1'b1;
        @(posedge CLK); #1 mon_en = 1'b1;
        randomize_prog();
        run_load(3, 3);
        chk("post_reset_last_addr", last_wr_addr, 32'h8);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
